// File: rtl/agu_pipe.sv
// agu_pipe: two-stage address generation unit for a radix-LANES, N = 2**N_LOG
// point transform. It walks (stage, group) pairs. Stage 1 registers the
// per-lane element orders. Stage 2 registers the per-lane memory address and
// bank, and drives the out_valid/out_ready stream.
// Optional feature macro: AGU_BANK_XOR_EN. When it is defined, the bank is the
// XOR of the base-2**B digits of the order. When it is undefined, the bank is
// the sum of those digits modulo LANES.
module agu_pipe #(
  parameter int LANES = 16,
  parameter int N_LOG = 12
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic                                             out_ready,
  output logic                                             out_valid,
  output logic [LANES*(N_LOG-$clog2(LANES))-1:0]           ma_idx,
  output logic [LANES*$clog2(LANES)-1:0]                   bn_idx,
  output logic [((N_LOG/$clog2(LANES)) > 1 ?
                 $clog2(N_LOG/$clog2(LANES)) : 1)-1:0]     out_stage,
  output logic                                             out_last,
  output logic                                             busy,
  output logic                                             done
);

  localparam int B      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int STAGES = N_LOG / B;
  localparam int MA_W   = N_LOG - B;
  localparam int GROUPS = 1 << MA_W;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int GW     = (MA_W > 0) ? MA_W : 1;

  localparam logic [SW-1:0]    STAGE_LAST = SW'(STAGES - 1);
  localparam logic [GW-1:0]    GROUP_LAST = GW'(GROUPS - 1);
  localparam logic [N_LOG-1:0] ALL_ONES   = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Reject configurations whose digit structure makes no sense.
  if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_chk_lanes
    $error("agu_pipe: LANES must be a power of two and at least 2");
  end
  if ((N_LOG % B) != 0) begin : g_chk_div
    $error("agu_pipe: N_LOG must be a multiple of log2(LANES)");
  end
  if (N_LOG <= B) begin : g_chk_size
    $error("agu_pipe: N_LOG must exceed log2(LANES) so the address field is non-empty");
  end

  // Control state and the walk counters.
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stage_cnt_q, stage_cnt_d;
  logic [GW-1:0] group_cnt_q, group_cnt_d;

  // Stage 1 holds the element orders of one (stage, group) pair.
  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*N_LOG-1:0] s1_order_q, s1_order_d;
  logic [SW-1:0]          s1_stage_q, s1_stage_d;
  logic                   s1_last_q, s1_last_d;

  // Stage 2 is the output register that the consumer sees.
  logic                  out_valid_q, out_valid_d;
  logic [LANES*MA_W-1:0] ma_q, ma_d;
  logic [LANES*B-1:0]    bn_q, bn_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  // Combinational helpers.
  logic                   s2_ready;
  logic                   s1_ready;
  logic                   gen_fire;
  logic                   final_pair;
  logic                   final_hs;
  logic [LANES*N_LOG-1:0] gen_order;
  logic [LANES*MA_W-1:0]  ma_calc;
  logic [LANES*B-1:0]     bn_calc;
  logic [N_LOG-1:0]       g_ext;
  logic [B-1:0]           acc;
  int                     sh;

  // Each stage accepts new data when it is empty or is emptying this cycle,
  // so the pipe runs without bubbles when the consumer stays ready.
  always_comb begin
    s2_ready   = !out_valid_q || out_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    gen_fire   = (state_q == ST_RUN) && s1_ready;
    final_pair = (stage_cnt_q == STAGE_LAST) && (group_cnt_q == GROUP_LAST);
    final_hs   = out_valid_q && out_ready && last_q;
  end

  // Compute the order of every lane for the current (stage, group) pair:
  // the high group bits move above the lane digit, and the low group bits
  // stay below it.
  always_comb begin
    gen_order = '0;
    g_ext     = N_LOG'(group_cnt_q);
    sh        = B * int'(stage_cnt_q);
    for (int k = 0; k < LANES; k++) begin
      gen_order[k*N_LOG +: N_LOG] = ((g_ext >> sh) << (sh + B))
                                  | (N_LOG'(k) << sh)
                                  | (g_ext & ~(ALL_ONES << sh));
    end
  end

  // Translate the stage 1 orders into a bank address (order without its
  // lowest digit) and a bank number that is built by hashing all digits.
  always_comb begin
    ma_calc = '0;
    bn_calc = '0;
    acc     = '0;
    for (int k = 0; k < LANES; k++) begin
      ma_calc[k*MA_W +: MA_W] = s1_order_q[k*N_LOG + B +: MA_W];
      acc = '0;
      for (int j = 0; j < STAGES; j++) begin
`ifdef AGU_BANK_XOR_EN
        acc = acc ^ s1_order_q[k*N_LOG + j*B +: B];
`else
        acc = acc + s1_order_q[k*N_LOG + j*B +: B];
`endif
      end
      bn_calc[k*B +: B] = acc;
    end
  end

  // Next-state logic for the FSM, the walk counters and both pipeline stages.
  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    group_cnt_d = group_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_order_d  = s1_order_q;
    s1_stage_d  = s1_stage_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    ma_d        = ma_q;
    bn_d        = bn_q;
    stage_d     = stage_q;
    last_d      = last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          stage_cnt_d = '0;
          group_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (gen_fire && final_pair) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (final_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (gen_fire) begin
      if (group_cnt_q == GROUP_LAST) begin
        group_cnt_d = '0;
        stage_cnt_d = (stage_cnt_q == STAGE_LAST) ? '0 : stage_cnt_q + 1'b1;
      end else begin
        group_cnt_d = group_cnt_q + 1'b1;
      end
      s1_valid_d = 1'b1;
      s1_order_d = gen_order;
      s1_stage_d = stage_cnt_q;
      s1_last_d  = final_pair;
    end else if (s2_ready) begin
      s1_valid_d = 1'b0;
    end

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      last_d      = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        ma_d    = ma_calc;
        bn_d    = bn_calc;
        stage_d = s1_stage_q;
      end
    end
  end

  // Register all state. Reset clears everything so the outputs read zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stage_cnt_q <= '0;
      group_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_order_q  <= '0;
      s1_stage_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ma_q        <= '0;
      bn_q        <= '0;
      stage_q     <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      group_cnt_q <= group_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_order_q  <= s1_order_d;
      s1_stage_q  <= s1_stage_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      ma_q        <= ma_d;
      bn_q        <= bn_d;
      stage_q     <= stage_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ma_idx    = ma_q;
  assign bn_idx    = bn_q;
  assign out_stage = stage_q;
  assign out_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_agu_pipe.sv
// tb_agu_pipe: directed bench for agu_pipe. It drives a small instance with
// LANES=4 and N_LOG=4, and a default instance with LANES=16 and N_LOG=12.
module tb_agu_pipe;

  localparam int L      = 16;
  localparam int BW     = 4;
  localparam int MW     = 8;
  localparam int NST    = 3;
  localparam int NGR    = 256;
  localparam int NBEATS = 768;

`ifdef AGU_BANK_XOR_EN
  localparam logic [7:0] S_BN_B1 = 8'hB1;
  localparam logic [7:0] S_BN_B7 = 8'h1B;
`else
  localparam logic [7:0] S_BN_B1 = 8'h39;
  localparam logic [7:0] S_BN_B7 = 8'h93;
`endif

  logic clk = 1'b0;
  logic rst;

  logic         start_s, ready_s, valid_s, last_s, busy_s, done_s;
  logic [7:0]   ma_s, bn_s;
  logic [0:0]   stage_s;
  logic         start_b, ready_b, valid_b, last_b, busy_b, done_b;
  logic [127:0] ma_b;
  logic [63:0]  bn_b;
  logic [1:0]   stage_b;

  int num_checks, num_passed, num_failed;
  int beats, cyc, done_cnt, exp_s, exp_g;
  logic stalled, start_pulsed;
  logic [127:0] prev_ma, prev_misc;
  logic [15:0]  mask;

  always #5 clk = ~clk;

  agu_pipe #(.LANES(4), .N_LOG(4)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .out_ready(ready_s),
    .out_valid(valid_s), .ma_idx(ma_s), .bn_idx(bn_s), .out_stage(stage_s),
    .out_last(last_s), .busy(busy_s), .done(done_s)
  );

  agu_pipe u_dut (
    .clk(clk), .rst(rst), .start(start_b), .out_ready(ready_b),
    .out_valid(valid_b), .ma_idx(ma_b), .bn_idx(bn_b), .out_stage(stage_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st_s, input logic rd_s,
                               input logic st_b, input logic rd_b);
    start_s = st_s;
    ready_s = rd_s;
    start_b = st_b;
    ready_b = rd_b;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    num_checks++;
    assert (observed === expected) num_passed++;
    else begin
      num_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Order of element k at (stage s, group g), in plain integer arithmetic.
  function automatic int unsigned exp_order(int s, int g, int k);
    int unsigned p;
    p = 1 << (s * BW);
    return (g / p) * (p * L) + k * p + (g % p);
  endfunction

  function automatic logic [127:0] exp_ma(int s, int g);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[k*MW +: MW] = 8'(exp_order(s, g, k) / L);
    return r;
  endfunction

  function automatic logic [127:0] exp_bn(int s, int g);
    logic [127:0] r;
    int unsigned o, acc, d;
    r = '0;
    for (int k = 0; k < L; k++) begin
      o = exp_order(s, g, k);
      acc = 0;
      for (int j = 0; j < NST; j++) begin
        d = o % L;
        o = o / L;
`ifdef AGU_BANK_XOR_EN
        acc = acc ^ d;
`else
        acc = (acc + d) % L;
`endif
      end
      r[k*BW +: BW] = 4'(acc);
    end
    return r;
  endfunction

  initial begin
    num_checks = 0;
    num_passed = 0;
    num_failed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    checkOutput("rst_small", 128'({valid_s, last_s, busy_s, done_s, stage_s, ma_s, bn_s}), 128'(0));
    checkOutput("rst_big_ma", ma_b, 128'(0));
    checkOutput("rst_big_misc", 128'({valid_b, last_b, busy_b, done_b, stage_b, bn_b}), 128'(0));
    rst = 1'b0;
    step();

    // Small configuration with the consumer always ready.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s_busy_after_start", 128'(busy_s), 128'(1));
    checkOutput("s_valid_edge0", 128'(valid_s), 128'(0));
    step();
    checkOutput("s_valid_edge1", 128'(valid_s), 128'(0));
    for (int b = 0; b < 8; b++) begin
      step();
      checkOutput("s_valid_beat", 128'(valid_s), 128'(1));
      checkOutput("s_last_beat", 128'(last_s), 128'(b == 7));
      if (b == 0) begin
        checkOutput("s_b0_ma", 128'(ma_s), 128'(8'hE4 & 8'h00));
        checkOutput("s_b0_bn", 128'(bn_s), 128'(8'hE4));
      end
      if (b == 1) begin
        checkOutput("s_b1_ma", 128'(ma_s), 128'(8'h55));
        checkOutput("s_b1_bn", 128'(bn_s), 128'(S_BN_B1));
        checkOutput("s_b1_stage", 128'(stage_s), 128'(0));
      end
      if (b == 2) checkOutput("s_b2_ma", 128'(ma_s), 128'(8'hAA));
      if (b == 5) begin
        checkOutput("s_b5_ma", 128'(ma_s), 128'(8'hE4));
        checkOutput("s_b5_bn", 128'(bn_s), 128'(S_BN_B1));
        checkOutput("s_b5_stage", 128'(stage_s), 128'(1));
      end
      if (b == 7) begin
        checkOutput("s_b7_ma", 128'(ma_s), 128'(8'hE4));
        checkOutput("s_b7_bn", 128'(bn_s), 128'(S_BN_B7));
      end
    end
    step();
    checkOutput("s_done_pulse", 128'({done_s, busy_s, valid_s}), 128'(3'b100));
    step();
    checkOutput("s_done_width", 128'({done_s, busy_s, valid_s}), 128'(3'b000));

    // Default configuration with random back-pressure and a start pulse while busy.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    beats = 0; cyc = 0; done_cnt = 0; exp_s = 0; exp_g = 0;
    stalled = 1'b0; start_pulsed = 1'b0;
    prev_ma = '0; prev_misc = '0;
    while (beats < NBEATS && cyc < 20000) begin
      cyc++;
      if (done_b) done_cnt++;
      if (stalled) begin
        checkOutput("stall_hold_ma", ma_b, prev_ma);
        checkOutput("stall_hold_misc", 128'({bn_b, stage_b, last_b, valid_b}), prev_misc);
      end
      ready_b = ($urandom_range(0, 3) != 0);
      start_b = (beats == 10) && !start_pulsed;
      if (start_b) start_pulsed = 1'b1;
      if (valid_b && ready_b) begin
        checkOutput("beat_ma", ma_b, exp_ma(exp_s, exp_g));
        checkOutput("beat_bn", 128'(bn_b), exp_bn(exp_s, exp_g));
        checkOutput("beat_stage", 128'(stage_b), 128'(exp_s));
        checkOutput("beat_last", 128'(last_b), 128'(exp_s == NST - 1 && exp_g == NGR - 1));
        checkOutput("beat_busy", 128'(busy_b), 128'(1));
        mask = '0;
        for (int k = 0; k < L; k++) mask[bn_b[k*BW +: BW]] = 1'b1;
        checkOutput("beat_banks_distinct", 128'(mask), 128'(16'hFFFF));
        beats++;
        if (exp_g == NGR - 1) begin
          exp_g = 0;
          exp_s++;
        end else begin
          exp_g++;
        end
      end
      stalled   = valid_b && !ready_b;
      prev_ma   = ma_b;
      prev_misc = 128'({bn_b, stage_b, last_b, valid_b});
      step();
    end
    start_b = 1'b0;
    ready_b = 1'b1;
    checkOutput("run_beat_count", 128'(beats), 128'(NBEATS));
    checkOutput("run_early_done", 128'(done_cnt), 128'(0));
    checkOutput("run_done_pulse", 128'({done_b, busy_b, valid_b}), 128'(3'b100));
    step();
    checkOutput("run_done_width", 128'({done_b, busy_b, valid_b}), 128'(3'b000));

    // Reset in the middle of a run, then restart.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    beats = 0; cyc = 0;
    while (beats < 300 && cyc < 2000) begin
      cyc++;
      if (valid_b) beats++;
      step();
    end
    checkOutput("pre_rst_valid", 128'({valid_b, busy_b}), 128'(2'b11));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ma", ma_b, 128'(0));
    checkOutput("mid_rst_misc", 128'({valid_b, last_b, busy_b, done_b, stage_b, bn_b}), 128'(0));
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done_b) done_cnt++;
    end
    checkOutput("post_rst_no_done", 128'(done_cnt), 128'(0));
    checkOutput("post_rst_idle", 128'({busy_b, valid_b}), 128'(0));

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (!valid_b && cyc < 10) begin
      step();
      cyc++;
    end
    checkOutput("restart_latency", 128'(cyc), 128'(2));
    checkOutput("restart_ma", ma_b, 128'(0));
    checkOutput("restart_stage", 128'(stage_b), 128'(0));
    checkOutput("restart_bn", 128'(bn_b), exp_bn(0, 0));
    beats = 0; cyc = 0;
    while (!done_b && cyc < 2000) begin
      if (valid_b) beats++;
      step();
      cyc++;
    end
    checkOutput("restart_beat_count", 128'(beats), 128'(NBEATS));
    checkOutput("restart_done", 128'(done_b), 128'(1));

    $display("[TB] %0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
AGU_PIPE -- requirements
Module: agu_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16: butterfly lanes and memory banks; power of two, at least 2.
REQ-002 SHALL have parameter N_LOG, default 12: log2 of transform size N.
REQ-003 SHALL derive B = log2(LANES), STAGES = N_LOG/B, GROUPS = N/LANES and MA_W = N_LOG-B; N_LOG not divisible by B SHALL be an elaboration error.
REQ-004 SHALL have ports as follows:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- out_ready  in  1  consumer accepts current beat.
- out_valid  out  1  ma_idx/bn_idx/out_stage/out_last valid.
- ma_idx  out  LANES*MA_W  lane k address at bits [k*MA_W +: MA_W].
- bn_idx  out  LANES*B  lane k bank at bits [k*B +: B].
- out_stage  out  ceil(log2(STAGES))  stage of current beat (min width 1).
- out_last  out  1  current beat is final beat of run.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at run completion.

Function
REQ-005 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after final (stage, group) pair enters stage 1; DRAIN -> IDLE when final beat handshakes.
REQ-006 SHALL walk stage s = 0..STAGES-1 (outer) and group g = 0..GROUPS-1 (inner), one pair per generator advance; beats per run = STAGES*GROUPS.
REQ-007 Stage 1 SHALL register orders: order_k = (g >> s*B) << ((s+1)*B) | k << s*B | (g mod 2^(s*B)), for k = 0..LANES-1.
REQ-008 Stage 2 SHALL register translation: ma_k = order_k >> B; bn_k = per REQ-017; stage and last tags SHALL travel with data.
REQ-009 Each beat SHALL map the LANES lanes to LANES distinct banks (conflict-free).
REQ-010 Handshake: beat transfers on out_valid & out_ready; while out_valid & !out_ready, all outputs SHALL hold stable and the generator SHALL not advance; stage 1 SHALL refill when empty or when stage 2 drains in the same cycle (no bubble at full throughput).
REQ-011 Latency: start sampled at edge 0 -> out_valid high after edge 2; with out_ready held high, one beat per cycle and no gaps.
REQ-012 done SHALL pulse in the cycle after final beat handshake; busy SHALL drop in that same cycle.
REQ-013 start while busy SHALL be ignored, with no restart and no state change.
REQ-014 out_valid SHALL never assert in IDLE; out_last SHALL be 1 only on beat (STAGES-1, GROUPS-1).

Reset
REQ-015 rst SHALL asynchronously force IDLE, counters 0, both pipeline valids 0, and all outputs 0 (ma_idx, bn_idx, out_stage, out_last, out_valid, busy, done).
REQ-016 rst mid-run SHALL abort with no done pulse; the next start SHALL begin at stage 0, group 0.

Configuration
REQ-017 Macro AGU_BANK_XOR_EN: defined -> bn_k = XOR of the STAGES base-2^B digits of order_k; undefined -> bn_k = sum of those digits mod LANES.

Verification
REQ-018 LANES=4, N_LOG=4, out_ready=1, start -> 8 beats; beat 1 (s=0, g=1): ma={1,1,1,1}, bn={1,2,3,0} (sum) or {1,0,3,2} (XOR).
REQ-019 Same config, beat 5 (s=1, g=1): orders 1,5,9,13 -> ma={0,1,2,3}, bn={1,2,3,0} (sum) or {1,0,3,2} (XOR); beat 7 out_last=1; done next cycle.
REQ-020 Defaults, out_ready toggled randomly -> exactly 768 beats, no duplicates or drops, and outputs stable during every stall.
REQ-021 Defaults, rst asserted at beat 300 -> all outputs 0 immediately and no done; restart -> first beat ma_0=0, out_stage=0.
REQ-022 start pulsed at beat 10 of a run -> ignored; beat count stays 768 and exactly one done pulse.
REQ-023 Defaults, every beat -> checker confirms 16 distinct banks, for both AGU_BANK_XOR_EN settings.
